// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the uart_rx_packet framer: FSM states,
// error codes and the default frame start marker.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK,
    ST_HOLD
  } state_t;

  localparam logic [1:0] ERR_LEN = 2'b01;
  localparam logic [1:0] ERR_CHK = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;

  localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

endpackage

// File: rtl/pkt_buffer.sv
// Payload store: DEPTH x 8 simple dual-port RAM with one synchronous write
// port and one registered read port; out-of-range reads return 8'h00.
module pkt_buffer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [DEPTH];

  // No reset on the array so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (32'(raddr) < DEPTH) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/uart_rx_packet.sv
// Frame assembler behind uart_rx_byte: SYNC, LEN, payload, CHK. Holds one
// verified packet for readout. Inter-byte timeout: UART_RX_PACKET_TIMEOUT_EN.
module uart_rx_packet
  import uart_pkt_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 43400,
  parameter int unsigned ADDR_W      = $clog2(MAX_LEN),
  parameter int unsigned LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_new,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              pkt_valid,
  output logic [LEN_W-1:0]  pkt_len,
  input  logic              pkt_ack,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              drop
);

  if (MAX_LEN < 2 || MAX_LEN > 255 || TIMEOUT_CYC < 2) begin : g_cfg_check
    $error("uart_rx_packet: unsupported MAX_LEN/TIMEOUT_CYC");
  end

  state_t             state, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]  idx, idx_d;
  logic [7:0]         acc, acc_d;
  logic [LEN_W-1:0]   pkt_len_d;
  logic               err_d, drop_d;
  logic [1:0]         code_d;
  logic               we;
  logic               tmo_hit;

`ifdef UART_RX_PACKET_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);
  logic [TMO_W-1:0] tmo_cnt;
  logic             in_frame;

  assign in_frame = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHECK);
  // A strobe arriving on the final count keeps the frame alive.
  assign tmo_hit  = in_frame && !rx_new && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (!in_frame || rx_new || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state;
    len_d     = len_q;
    idx_d     = idx;
    acc_d     = acc;
    pkt_len_d = pkt_len;
    err_d     = 1'b0;
    code_d    = err_code;
    drop_d    = 1'b0;
    we        = 1'b0;

    if (tmo_hit) begin
      err_d   = 1'b1;
      code_d  = ERR_TMO;
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_new && rx_data == SYNC_BYTE) state_d = ST_LEN;
        end
        ST_LEN: begin
          if (rx_new) begin
            len_d = rx_data[LEN_W-1:0];
            acc_d = rx_data;
            idx_d = '0;
            if (rx_data > 8'(MAX_LEN)) begin
              err_d   = 1'b1;
              code_d  = ERR_LEN;
              state_d = ST_IDLE;
            end else if (rx_data == 8'h00) begin
              state_d = ST_CHECK;
            end else begin
              state_d = ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (rx_new) begin
            we    = 1'b1;
            acc_d = 8'(acc + rx_data);
            idx_d = idx + 1'b1;
            if (LEN_W'(idx) == len_q - LEN_W'(1)) state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (rx_new) begin
            if (8'(acc + rx_data) == 8'h00) begin
              state_d   = ST_HOLD;
              pkt_len_d = len_q;
            end else begin
              err_d   = 1'b1;
              code_d  = ERR_CHK;
              state_d = ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          // An ack releases the packet and lets a same-cycle byte start the next frame.
          if (pkt_ack) begin
            state_d = (rx_new && rx_data == SYNC_BYTE) ? ST_LEN : ST_IDLE;
          end else if (rx_new) begin
            drop_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      len_q    <= '0;
      idx      <= '0;
      acc      <= '0;
      pkt_len  <= '0;
      err      <= 1'b0;
      err_code <= '0;
      drop     <= 1'b0;
    end else begin
      state    <= state_d;
      len_q    <= len_d;
      idx      <= idx_d;
      acc      <= acc_d;
      pkt_len  <= pkt_len_d;
      err      <= err_d;
      err_code <= code_d;
      drop     <= drop_d;
    end
  end

  assign pkt_valid = (state == ST_HOLD);

  pkt_buffer #(
    .DEPTH  (MAX_LEN),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (idx),
    .wdata (rx_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_uart_rx_packet.sv
// Directed table-driven bench for uart_rx_packet, with hand-written reset and
// inter-byte gap sequences (timeout checks under UART_RX_PACKET_TIMEOUT_EN).
module tb_uart_rx_packet;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_new;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       pkt_valid;
  logic [4:0] pkt_len;
  logic       pkt_ack;
  logic       err;
  logic [1:0] err_code;
  logic       drop;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_rx_packet dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_new    (rx_new),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .pkt_valid (pkt_valid),
    .pkt_len   (pkt_len),
    .pkt_ack   (pkt_ack),
    .err       (err),
    .err_code  (err_code),
    .drop      (drop)
  );

  typedef struct {
    bit [63:0]  tag;
    bit         nw;
    logic [7:0] d;
    bit         ack;
    logic [3:0] ra;
    bit         v;
    logic [4:0] l;
    bit         e;
    logic [1:0] c;
    bit         dr;
    bit         crd;
    logic [7:0] rd;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic add(input bit [63:0] t, input bit nw, input logic [7:0] d, input bit ack,
                     input logic [3:0] ra, input bit v, input logic [4:0] l, input bit e,
                     input logic [1:0] c, input bit dr, input bit crd, input logic [7:0] rd);
    vec_t x;
    x.tag = t; x.nw = nw; x.d = d; x.ack = ack; x.ra = ra; x.v = v; x.l = l;
    x.e = e; x.c = c; x.dr = dr; x.crd = crd; x.rd = rd;
    vq.push_back(x);
  endtask

  task automatic addb(input bit [63:0] t, input logic [7:0] d, input bit v,
                      input logic [4:0] l, input bit e, input logic [1:0] c);
    add(t, 1'b1, d, 1'b0, 4'd0, v, l, e, c, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic addrd(input bit [63:0] t, input logic [3:0] ra, input logic [7:0] rd,
                       input bit v, input logic [4:0] l, input logic [1:0] c);
    add(t, 1'b0, 8'h00, 1'b0, ra, v, l, 1'b0, c, 1'b0, 1'b1, rd);
  endtask

  task automatic addack(input bit [63:0] t, input logic [4:0] l, input logic [1:0] c);
    add(t, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, l, 1'b0, c, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic run_vectors();
    for (int unsigned i = 0; i < vq.size(); i++) begin
      rx_new  = vq[i].nw;
      rx_data = vq[i].d;
      pkt_ack = vq[i].ack;
      rd_addr = vq[i].ra;
      @(posedge clk);
      #1;
      rx_new  = 1'b0;
      pkt_ack = 1'b0;
      chk($sformatf("%0s[%0d].valid", vq[i].tag, i), 32'(pkt_valid), 32'(vq[i].v));
      chk($sformatf("%0s[%0d].len", vq[i].tag, i), 32'(pkt_len), 32'(vq[i].l));
      chk($sformatf("%0s[%0d].err", vq[i].tag, i), 32'(err), 32'(vq[i].e));
      chk($sformatf("%0s[%0d].code", vq[i].tag, i), 32'(err_code), 32'(vq[i].c));
      chk($sformatf("%0s[%0d].drop", vq[i].tag, i), 32'(drop), 32'(vq[i].dr));
      if (vq[i].crd) chk($sformatf("%0s[%0d].rd", vq[i].tag, i), 32'(rd_data), 32'(vq[i].rd));
    end
    vq.delete();
  endtask

  task automatic idle(input int unsigned n);
    rx_new  = 1'b0;
    pkt_ack = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string t);
    chk({t, ".valid"}, 32'(pkt_valid), 32'd0);
    chk({t, ".len"},   32'(pkt_len),   32'd0);
    chk({t, ".err"},   32'(err),       32'd0);
    chk({t, ".code"},  32'(err_code),  32'd0);
    chk({t, ".drop"},  32'(drop),      32'd0);
    chk({t, ".rd"},    32'(rd_data),   32'd0);
  endtask

  initial begin
    rst = 1'b1; rx_new = 1'b0; rx_data = 8'h00; pkt_ack = 1'b0; rd_addr = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Good frame, readback, release
    addb("good", 8'hA5, 0, 5'd0, 0, 2'd0);
    addb("good", 8'h03, 0, 5'd0, 0, 2'd0);
    addb("good", 8'h11, 0, 5'd0, 0, 2'd0);
    addb("good", 8'h22, 0, 5'd0, 0, 2'd0);
    addb("good", 8'h33, 0, 5'd0, 0, 2'd0);
    addb("good", 8'h97, 1, 5'd3, 0, 2'd0);
    addrd("good_rd", 4'd0, 8'h11, 1, 5'd3, 2'd0);
    addrd("good_rd", 4'd1, 8'h22, 1, 5'd3, 2'd0);
    addrd("good_rd", 4'd2, 8'h33, 1, 5'd3, 2'd0);
    addack("good_ack", 5'd3, 2'd0);

    // Bad checksum then a good one-byte frame
    addb("badchk", 8'hA5, 0, 5'd3, 0, 2'd0);
    addb("badchk", 8'h01, 0, 5'd3, 0, 2'd0);
    addb("badchk", 8'h55, 0, 5'd3, 0, 2'd0);
    addb("badchk", 8'h00, 0, 5'd3, 1, 2'd2);
    addb("good1", 8'hA5, 0, 5'd3, 0, 2'd2);
    addb("good1", 8'h01, 0, 5'd3, 0, 2'd2);
    addb("good1", 8'h55, 0, 5'd3, 0, 2'd2);
    addb("good1", 8'hAA, 1, 5'd1, 0, 2'd2);
    addrd("good1_rd", 4'd0, 8'h55, 1, 5'd1, 2'd2);
    addack("good1_ack", 5'd1, 2'd2);

    // Garbage ignored, length error, zero-length frame
    addb("garbage", 8'h00, 0, 5'd1, 0, 2'd2);
    addb("garbage", 8'h7E, 0, 5'd1, 0, 2'd2);
    addb("lenerr", 8'hA5, 0, 5'd1, 0, 2'd2);
    addb("lenerr", 8'h14, 0, 5'd1, 1, 2'd1);
    addb("len0", 8'hA5, 0, 5'd1, 0, 2'd1);
    addb("len0", 8'h00, 0, 5'd1, 0, 2'd1);
    addb("len0", 8'h00, 1, 5'd0, 0, 2'd1);
    addack("len0_ack", 5'd0, 2'd1);

    // Length boundary: 17 rejected, 16 accepted
    addb("len17", 8'hA5, 0, 5'd0, 0, 2'd1);
    addb("len17", 8'h11, 0, 5'd0, 1, 2'd1);
    addb("len16", 8'hA5, 0, 5'd0, 0, 2'd1);
    addb("len16", 8'h10, 0, 5'd0, 0, 2'd1);
    for (int unsigned i = 0; i < 16; i++) addb("len16", 8'(i), 0, 5'd0, 0, 2'd1);
    addb("len16", 8'h78, 1, 5'd16, 0, 2'd1);
    addrd("len16_rd", 4'd15, 8'h0F, 1, 5'd16, 2'd1);
    addrd("len16_rd", 4'd0, 8'h00, 1, 5'd16, 2'd1);
    addack("len16_ack", 5'd16, 2'd1);

    // Overrun while held, then ack + SYNC in the same cycle
    addb("ovr", 8'hA5, 0, 5'd16, 0, 2'd1);
    addb("ovr", 8'h03, 0, 5'd16, 0, 2'd1);
    addb("ovr", 8'h11, 0, 5'd16, 0, 2'd1);
    addb("ovr", 8'h22, 0, 5'd16, 0, 2'd1);
    addb("ovr", 8'h33, 0, 5'd16, 0, 2'd1);
    addb("ovr", 8'h97, 1, 5'd3, 0, 2'd1);
    add("ovr_drop", 1, 8'h5A, 0, 4'd0, 1, 5'd3, 0, 2'd1, 1, 1, 8'h11);
    add("ovr_acks", 1, 8'hA5, 1, 4'd0, 0, 5'd3, 0, 2'd1, 0, 0, 8'h00);
    addb("ovr2", 8'h02, 0, 5'd3, 0, 2'd1);
    add("ovr2_ack", 1, 8'h01, 1, 4'd0, 0, 5'd3, 0, 2'd1, 0, 0, 8'h00);
    addb("ovr2", 8'h02, 0, 5'd3, 0, 2'd1);
    addb("ovr2", 8'hFB, 1, 5'd2, 0, 2'd1);
    addrd("ovr2_rd", 4'd0, 8'h01, 1, 5'd2, 2'd1);
    addrd("ovr2_rd", 4'd1, 8'h02, 1, 5'd2, 2'd1);
    addack("ovr2_ack", 5'd2, 2'd1);

    // SYNC value inside payload is data
    addb("syncpl", 8'hA5, 0, 5'd2, 0, 2'd1);
    addb("syncpl", 8'h02, 0, 5'd2, 0, 2'd1);
    addb("syncpl", 8'hA5, 0, 5'd2, 0, 2'd1);
    addb("syncpl", 8'hA5, 0, 5'd2, 0, 2'd1);
    addb("syncpl", 8'hB4, 1, 5'd2, 0, 2'd1);
    addrd("syncpl_rd", 4'd1, 8'hA5, 1, 5'd2, 2'd1);
    addack("syncpl_ack", 5'd2, 2'd1);
    run_vectors();

    // Reset in the middle of a frame
    addb("rstmid", 8'hA5, 0, 5'd2, 0, 2'd1);
    addb("rstmid", 8'h04, 0, 5'd2, 0, 2'd1);
    addb("rstmid", 8'h10, 0, 5'd2, 0, 2'd1);
    addrd("rstmid_rd", 4'd0, 8'h10, 0, 5'd2, 2'd1);
    run_vectors();
    rst = 1'b1;
    #2;
    chk_reset_outputs("rstmid_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    addb("afterrst", 8'hA5, 0, 5'd0, 0, 2'd0);
    addb("afterrst", 8'h01, 0, 5'd0, 0, 2'd0);
    addb("afterrst", 8'h20, 0, 5'd0, 0, 2'd0);
    addb("afterrst", 8'hDF, 1, 5'd1, 0, 2'd0);
    addrd("afterrst_rd", 4'd0, 8'h20, 1, 5'd1, 2'd0);
    addack("afterrst_ack", 5'd1, 2'd0);
    run_vectors();

`ifdef UART_RX_PACKET_TIMEOUT_EN
    addb("tmo", 8'hA5, 0, 5'd1, 0, 2'd0);
    addb("tmo", 8'h02, 0, 5'd1, 0, 2'd0);
    addb("tmo", 8'h01, 0, 5'd1, 0, 2'd0);
    run_vectors();
    idle(43398);
    add("tmo_edge", 0, 8'h00, 0, 4'd0, 0, 5'd1, 0, 2'd0, 0, 0, 8'h00);
    add("tmo_hit", 0, 8'h00, 0, 4'd0, 0, 5'd1, 1, 2'd3, 0, 0, 8'h00);
    addb("alive", 8'hA5, 0, 5'd1, 0, 2'd3);
    addb("alive", 8'h02, 0, 5'd1, 0, 2'd3);
    addb("alive", 8'h01, 0, 5'd1, 0, 2'd3);
    run_vectors();
    idle(43398);
    addb("alive", 8'h02, 0, 5'd1, 0, 2'd3);
    addb("alive", 8'hFB, 1, 5'd2, 0, 2'd3);
    addack("alive_ack", 5'd2, 2'd3);
    run_vectors();
`else
    addb("gap", 8'hA5, 0, 5'd1, 0, 2'd0);
    addb("gap", 8'h02, 0, 5'd1, 0, 2'd0);
    addb("gap", 8'h01, 0, 5'd1, 0, 2'd0);
    run_vectors();
    idle(200);
    add("gap_idle", 0, 8'h00, 0, 4'd0, 0, 5'd1, 0, 2'd0, 0, 0, 8'h00);
    addb("gap", 8'h02, 0, 5'd1, 0, 2'd0);
    addb("gap", 8'hFB, 1, 5'd2, 0, 2'd0);
    addack("gap_ack", 5'd2, 2'd0);
    run_vectors();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_packet.md
Name: uart_rx_packet

Overview:
- Downstream consumer of uart_rx_byte: takes its `data`/`new_data` byte stream and assembles framed packets.
- Frame format: SYNC, LEN, LEN payload bytes, CHK.
- Validated payloads are held in an internal buffer and read by fabric logic through an address port. Each packet is released with an ack.
- Framing, length and checksum errors are flagged with a one-cycle pulse.

Parameters:
- SYNC_BYTE, 8'hA5: frame start marker.
- MAX_LEN, 16: maximum payload bytes; also the buffer depth.
- TIMEOUT_CYC, 43400: inter-byte timeout in clk cycles (about 10 byte times at CLK_PER_BIT 434). Used only with the optional feature.

Ports:
- clk  in  1: system clock.
- rst  in  1: reset, asynchronous and active-high.
- rx_data  in  8: byte from uart_rx_byte `data`.
- rx_new  in  1: one-cycle strobe from uart_rx_byte `new_data`; rx_data is valid in that cycle.
- rd_addr  in  ADDR_W: payload read address, where ADDR_W = $clog2(MAX_LEN).
- rd_data  out  8: buffer[rd_addr], registered, 1-cycle latency.
- pkt_valid  out  1: complete, verified packet is held.
- pkt_len  out  LEN_W: payload length of the held packet, where LEN_W = $clog2(MAX_LEN+1).
- pkt_ack  in  1: consumer releases the held packet.
- err  out  1: one-cycle pulse on a frame error.
- err_code  out  2: 01 length, 10 checksum, 11 timeout. Holds its value until the next err.
- drop  out  1: one-cycle pulse when a byte is discarded because a packet is held.

Behaviour:
- Reset (async, any state): state=IDLE. pkt_valid=0, pkt_len=0, err=0, err_code=00, drop=0, rd_data=0. Buffer contents are don't-care.
- States: IDLE, LEN, PAYLOAD, CHECK, HOLD. Every transition below occurs only on a cycle with rx_new=1, except pkt_ack and the timeout.
- IDLE:
  - rx_data==SYNC_BYTE -> LEN.
  - Any other byte is ignored silently, with no err.
- LEN:
  - Capture the length into len_q.
  - Initialise the checksum accumulator to the length byte (8-bit).
  - len>MAX_LEN -> err pulse, code 01, go to IDLE.
  - len==0 -> go to CHECK.
  - Otherwise -> go to PAYLOAD with index=0.
- PAYLOAD:
  - Write buffer[index]=rx_data; add rx_data to the accumulator mod 256; increment index.
  - When index reaches len_q-1 on a write -> go to CHECK.
  - A SYNC_BYTE value inside the payload is data and is not a resync.
- CHECK:
  - (accumulator + rx_data) mod 256 == 0 -> go to HOLD. pkt_valid rises in the cycle after the CHK strobe; pkt_len=len_q.
  - Otherwise -> err pulse, code 10, go to IDLE. Buffer contents are undefined and pkt_valid stays 0.
- HOLD:
  - pkt_valid=1. Buffer and pkt_len are frozen.
  - rx_new without pkt_ack -> drop pulse; the byte is discarded.
  - pkt_ack -> pkt_valid=0 next cycle; go to IDLE.
  - Simultaneous pkt_ack and rx_new: the byte is evaluated as if in IDLE, so a SYNC byte goes directly to LEN. No drop pulse.
- pkt_ack outside HOLD is ignored.
- Reads: rd_data is registered every cycle from buffer[rd_addr]. Reads are legal at any time but only meaningful while pkt_valid=1.
- rd_addr>=MAX_LEN returns 8'h00.
- Only one of err and drop can pulse in a given cycle.

Optional Feature:
- Macro: UART_RX_PACKET_TIMEOUT_EN.
- When defined:
  - In LEN, PAYLOAD and CHECK, a counter increments each clk and clears on every rx_new.
  - When the counter reaches TIMEOUT_CYC-1 -> err pulse, code 11, go to IDLE.
  - The counter is held at 0 in IDLE and HOLD.
- When undefined:
  - No counter is built and a partial frame waits indefinitely.
  - err_code 11 is never produced.

Decomposition:
- Package uart_pkt_pkg holds:
  - state encodings (IDLE, LEN, PAYLOAD, CHECK, HOLD);
  - error code constants (ERR_LEN=2'b01, ERR_CHK=2'b10, ERR_TMO=2'b11);
  - default SYNC_BYTE.
- Sub-module pkt_buffer: simple dual-port RAM, MAX_LEN x 8. One synchronous write port (we, waddr, wdata) and one registered read port. Intended to infer distributed RAM.

Test Plan:
- Good frame: bytes A5 03 11 22 33 97 -> pkt_valid=1 one cycle after the last strobe, pkt_len=3, rd_addr 0/1/2 -> rd_data 11/22/33, err=0. pkt_ack -> pkt_valid=0.
- Bad checksum: A5 01 55 00 -> err pulse with err_code=10, pkt_valid stays 0. Following A5 01 55 AA -> pkt_valid=1, pkt_len=1, rd_data@0=55.
- Length error and resync: 00 7E A5 14 -> err_code=01 on the 0x14 strobe and no err on the leading garbage. Then A5 00 00 -> pkt_valid=1, pkt_len=0.
- Overrun: hold packet from the good-frame test, send 5A with no ack -> drop pulse, rd_data@0 still 11. Then send pkt_ack and A5 in the same cycle -> no drop; next frame 02 01 02 FB accepted with pkt_len=2.
- Reset mid-frame: A5 04 10, assert rst for 1 cycle -> all outputs return to reset values. Then A5 01 20 DF -> valid, pkt_len=1.
- With UART_RX_PACKET_TIMEOUT_EN: A5 02 01, then idle 43400 cycles -> err_code=11 and the state returns to IDLE. Idling 43398 cycles and then sending 02 FB keeps the frame alive and it is accepted.
